if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Holds the program counter (PC) and drives the byte address to instruction memory. Captures the 32-bit little-endian instruction word returned combinationally in the same cycle. Registers instruction, PC and PC+4 into the IF/ID pipeline register, with stall, flush, redirect and halt control from downstream.

Parameters:
P_RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
P_NOP, 32'h0000_0013, instruction word placed in IF/ID for a bubble.

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_stall  in  1  hold PC and IF/ID contents
i_flush  in  1  load bubble into IF/ID
i_redirect  in  1  load PC from i_target (branch/jump/trap)
i_target  in  32  redirect byte address
i_halt  in  1  enter HALTED state
i_instr  in  32  instruction word from instruction memory at o_imem_adr
o_imem_adr  out  32  current PC, driven straight from PC register
o_id_instr  out  32  IF/ID instruction
o_id_pc  out  32  IF/ID PC of that instruction
o_id_pc_plus4  out  32  IF/ID PC+4
o_id_valid  out  1  IF/ID holds a real instruction
o_misaligned  out  1  one-cycle pulse: accepted redirect target had [1:0] != 0
o_halted  out  1  high while in HALTED

Behaviour:
- Reset, when i_rst is high at a clock edge:
  - PC <= P_RESET_VECTOR; state <= BOOT.
  - o_id_instr <= P_NOP; o_id_pc <= 0; o_id_pc_plus4 <= 0.
  - o_id_valid <= 0; o_misaligned <= 0; o_halted <= 0.
- Reset mid-operation discards all in-flight state with the same result. Reset has priority over every other input.
- A "bubble" means: o_id_instr = P_NOP, o_id_valid = 0, o_id_pc and o_id_pc_plus4 unchanged.
- States:
  - BOOT: lasts exactly one cycle after reset is released. IF/ID loads a bubble, PC holds, then RUN. All control inputs except i_rst are ignored in BOOT.
  - RUN: normal fetch.
  - HALTED: PC holds; IF/ID loads a bubble every cycle; o_halted = 1.
- RUN priority per edge, highest first:
  1. i_redirect: PC <= {i_target[31:2], 2'b00}; IF/ID <= bubble. i_stall and i_halt are ignored that cycle. o_misaligned <= (i_target[1:0] != 0).
  2. i_stall: PC holds. IF/ID holds, or loads a bubble if i_flush is also high.
  3. i_halt: state <= HALTED; PC holds; IF/ID <= bubble.
  4. Normal: IF/ID <= {i_instr, PC, PC+4, valid = 1}; PC <= PC+4. If i_flush is high, IF/ID loads a bubble instead, but PC still advances.
- HALTED:
  - i_redirect -> RUN; PC <= aligned target; o_misaligned as above.
  - i_stall, i_flush and i_halt have no effect.
  - Only i_redirect or i_rst leaves HALTED.
- o_misaligned is 0 on every cycle without an accepted redirect.
- Latency: an instruction at address A, fetched in RUN with no stall, appears on the IF/ID outputs on the edge ending the cycle in which PC = A.
  - After reset release: BOOT cycle, then the first valid instruction (at P_RESET_VECTOR) appears in IF/ID at the end of the second cycle.
- Arithmetic: PC+4 is a 32-bit unsigned add that wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No overflow flag.
- PC[1:0] is always 2'b00.
- o_imem_adr changes only at clock edges; no combinational path from any input to o_imem_adr.

Test Plan:
- Reset then 4 free-running cycles, memory bytes at 0..15 holding words 11111111, 22222222, 33333333, 44444444 -> o_id_valid 0 for the BOOT cycle. Then IF/ID shows (11111111, pc 0, pc+4 4), then (22222222, 4, 8), then (33333333, 8, 12).
- i_stall high 3 cycles at PC=8 -> o_imem_adr stays 8 and IF/ID is frozen on (22222222, 4). Fetch resumes with 33333333 at pc 8 after release.
- i_redirect with target 32'h0000_0042 while i_stall is also high -> next o_imem_adr = 32'h40, o_misaligned pulses 1 for one cycle, IF/ID is a bubble (P_NOP, valid 0).
- i_halt in RUN -> o_halted 1, PC frozen, valid 0 each cycle, i_flush and i_stall ignored. A later redirect to 32'h100 -> o_halted 0, o_imem_adr = 32'h100.
- PC forced to 32'hFFFF_FFFC via redirect, one free cycle -> o_id_pc_plus4 = 0 and o_imem_adr = 0.
- i_rst asserted mid-stream with valid 1 -> next edge: o_id_valid 0, o_imem_adr = P_RESET_VECTOR, BOOT repeats.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID pipeline register under stall/flush/redirect/halt control.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | single cycle after reset release; bubble into IF/ID, PC holds
// RUN    | normal fetch, redirect > stall > halt > advance
// HALTED | PC frozen, IF/ID bubbles each cycle; only redirect/reset exit
module if_fetch_stage #(
    parameter logic [31:0] P_RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] P_NOP          = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    input  logic        i_halt,
    input  logic [31:0] i_instr,
    output logic [31:0] o_imem_adr,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4,
    output logic        o_id_valid,
    output logic        o_misaligned,
    output logic        o_halted
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic [31:0] id_instr_d, id_pc_d, id_pc_plus4_d;
    logic        id_valid_d;
    logic        misaligned_d;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = {i_target[31:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_BOOT;
            pc_q          <= {P_RESET_VECTOR[31:2], 2'b00};
            o_id_instr    <= P_NOP;
            o_id_pc       <= 32'd0;
            o_id_pc_plus4 <= 32'd0;
            o_id_valid    <= 1'b0;
            o_misaligned  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            o_id_instr    <= id_instr_d;
            o_id_pc       <= id_pc_d;
            o_id_pc_plus4 <= id_pc_plus4_d;
            o_id_valid    <= id_valid_d;
            o_misaligned  <= misaligned_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_instr_d    = o_id_instr;
        id_pc_d       = o_id_pc;
        id_pc_plus4_d = o_id_pc_plus4;
        id_valid_d    = o_id_valid;
        misaligned_d  = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                id_instr_d = P_NOP;
                id_valid_d = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (i_redirect) begin
                    pc_d         = target_aligned;
                    id_instr_d   = P_NOP;
                    id_valid_d   = 1'b0;
                    misaligned_d = |i_target[1:0];
                end else if (i_stall) begin
                    if (i_flush) begin
                        id_instr_d = P_NOP;
                        id_valid_d = 1'b0;
                    end
                end else if (i_halt) begin
                    state_d    = S_HALTED;
                    id_instr_d = P_NOP;
                    id_valid_d = 1'b0;
                end else begin
                    pc_d = pc_plus4;
                    if (i_flush) begin
                        id_instr_d = P_NOP;
                        id_valid_d = 1'b0;
                    end else begin
                        id_instr_d    = i_instr;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_plus4;
                        id_valid_d    = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                id_instr_d = P_NOP;
                id_valid_d = 1'b0;
                if (i_redirect) begin
                    state_d      = S_RUN;
                    pc_d         = target_aligned;
                    misaligned_d = |i_target[1:0];
                end
            end
            default: begin
                state_d    = S_BOOT;
                id_instr_d = P_NOP;
                id_valid_d = 1'b0;
            end
        endcase
    end

    // PC is a plain register, so memory address never sees input glitches.
    assign o_imem_adr = pc_q;
    assign o_halted   = (state_q == S_HALTED);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected IF/ID and control outputs are
// queued as each cycle's stimulus is applied and compared after the edge.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect, halt;
    logic [31:0] target, instr;
    logic [31:0] imem_adr, id_instr, id_pc, id_pc_plus4;
    logic        id_valid, misaligned, halted;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        valid;
        logic [31:0] adr;
        logic        mis;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_fetch_stage #(
        .P_RESET_VECTOR(32'h0000_0000),
        .P_NOP         (NOP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_redirect   (redirect),
        .i_target     (target),
        .i_halt       (halt),
        .i_instr      (instr),
        .o_imem_adr   (imem_adr),
        .o_id_instr   (id_instr),
        .o_id_pc      (id_pc),
        .o_id_pc_plus4(id_pc_plus4),
        .o_id_valid   (id_valid),
        .o_misaligned (misaligned),
        .o_halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h8:   return 32'h3333_3333;
            32'hC:   return 32'h4444_4444;
            default: return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    always_comb instr = mem(imem_adr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rd, input logic [31:0] t, input logic h);
        rst = r; stall = s; flush = f; redirect = rd; target = t; halt = h;
    endtask

    // Queue expectation for the cycle being driven, clock it, then score it.
    task automatic step(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic [31:0] e_plus4, input logic e_valid, input logic [31:0] e_adr,
                        input logic e_mis, input logic e_halted);
        exp_t e;
        e.instr = e_instr; e.pc = e_pc; e.plus4 = e_plus4; e.valid = e_valid;
        e.adr = e_adr; e.mis = e_mis; e.halted = e_halted;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".instr"},  id_instr,             e.instr);
            check({tag, ".pc"},     id_pc,                e.pc);
            check({tag, ".plus4"},  id_pc_plus4,          e.plus4);
            check({tag, ".valid"},  {31'd0, id_valid},    {31'd0, e.valid});
            check({tag, ".adr"},    imem_adr,             e.adr);
            check({tag, ".mis"},    {31'd0, misaligned},  {31'd0, e.mis});
            check({tag, ".halted"}, {31'd0, halted},      {31'd0, e.halted});
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        step("reset", NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("boot",  NOP,          32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("run0",  32'h1111_1111, 32'h0, 32'h4, 1'b1, 32'h4, 1'b0, 1'b0);
        step("run1",  32'h2222_2222, 32'h4, 32'h8, 1'b1, 32'h8, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("stall", 32'h2222_2222, 32'h4, 32'h8, 1'b1, 32'h8, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("resume", 32'h3333_3333, 32'h8, 32'hC,  1'b1, 32'hC,  1'b0, 1'b0);
        step("run3",   32'h4444_4444, 32'hC, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("flush_adv", NOP, 32'hC, 32'h10, 1'b0, 32'h14, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step("stall_flush", NOP, 32'hC, 32'h10, 1'b0, 32'h14, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 1'b1);
        step("redir_mis", NOP, 32'hC, 32'h10, 1'b0, 32'h40, 1'b1, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("after_redir", mem(32'h40), 32'h40, 32'h44, 1'b1, 32'h44, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step("halt", NOP, 32'h40, 32'h44, 1'b0, 32'h44, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step("halted_sf", NOP, 32'h40, 32'h44, 1'b0, 32'h44, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("halted_idle", NOP, 32'h40, 32'h44, 1'b0, 32'h44, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        step("unhalt", NOP, 32'h40, 32'h44, 1'b0, 32'h100, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("run_100", mem(32'h100), 32'h100, 32'h104, 1'b1, 32'h104, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step("redir_top", NOP, 32'h100, 32'h104, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("wrap", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 1'b0);
        step("redir_7", NOP, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h4, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("run_4", 32'h2222_2222, 32'h4, 32'h8, 1'b1, 32'h8, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("mid_reset", NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
        step("boot_ignore", NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("reboot_run", 32'h1111_1111, 32'h0, 32'h4, 1'b1, 32'h4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
